// File: rtl/id_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_reg_pkg
// Shared CPU definitions used by the ID stage: opcode encodings, instruction
// field bit positions, the canonical NOP word, register-index width and the
// reset values of the ID pipeline register.
// ---------------------------------------------------------------------------
package id_reg_pkg;

    localparam int CPU_REG_ADDR_W = 5;

    // Instruction field positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RA_MSB  = 25;
    localparam int RA_LSB  = 21;
    localparam int RB_MSB  = 20;
    localparam int RB_LSB  = 16;
    localparam int RC_MSB  = 15;
    localparam int RC_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    typedef enum logic [5:0] {
        OP_NOP  = 6'h00,
        OP_ADD  = 6'h01,
        OP_ADDI = 6'h02,
        OP_LD   = 6'h03,
        OP_ST   = 6'h04,
        OP_BEQ  = 6'h05,
        OP_JMP  = 6'h06
    } opcode_e;

    localparam logic [31:0] ISA_NOP = 32'h0000_0000;

    // Reset / bubble values of the ID register
    localparam logic [5:0] RST_OP     = OP_NOP;
    localparam logic       RST_EN     = 1'b0;
    localparam logic       RST_DST_EN = 1'b0;

    // Map a raw opcode field onto the defined set; anything else is a NOP.
    function automatic opcode_e legal_op(input logic [5:0] raw);
        opcode_e op;
        case (raw)
            6'h01:   op = OP_ADD;
            6'h02:   op = OP_ADDI;
            6'h03:   op = OP_LD;
            6'h04:   op = OP_ST;
            6'h05:   op = OP_BEQ;
            6'h06:   op = OP_JMP;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_reg_decoder.sv
// ---------------------------------------------------------------------------
// id_decoder
// Purely combinational instruction decoder for the ID stage.
//   insn_i   : fetched instruction word
//   op_o     : legalised opcode (undefined -> NOP)
//   ra_o/rb_o: source register indices taken straight from the instruction
//   dst_o    : destination index (rc for ADD, rb for ADDI/LD, 0 otherwise)
//   use_ra_o/use_rb_o : opcode actually reads ra / rb
//   writes_o : opcode writes a register
//   imm_o    : sign-extended 16-bit immediate
// ---------------------------------------------------------------------------
module id_decoder
    import id_reg_pkg::*;
#(
    parameter int WORD_DATA_W = 32
) (
    input  logic [WORD_DATA_W-1:0]    insn_i,
    output opcode_e                   op_o,
    output logic [CPU_REG_ADDR_W-1:0] ra_o,
    output logic [CPU_REG_ADDR_W-1:0] rb_o,
    output logic [CPU_REG_ADDR_W-1:0] dst_o,
    output logic                      use_ra_o,
    output logic                      use_rb_o,
    output logic                      writes_o,
    output logic [WORD_DATA_W-1:0]    imm_o
);

    logic [CPU_REG_ADDR_W-1:0] rc_s;

    assign op_o  = legal_op(insn_i[OP_MSB:OP_LSB]);
    assign ra_o  = insn_i[RA_MSB:RA_LSB];
    assign rb_o  = insn_i[RB_MSB:RB_LSB];
    assign rc_s  = insn_i[RC_MSB:RC_LSB];
    assign imm_o = {{(WORD_DATA_W-IMM_W){insn_i[IMM_MSB]}}, insn_i[IMM_MSB:IMM_LSB]};

    // Per-opcode source usage and destination selection
    always_comb begin
        use_ra_o = 1'b0;
        use_rb_o = 1'b0;
        writes_o = 1'b0;
        dst_o    = '0;
        case (op_o)
            OP_ADD: begin
                use_ra_o = 1'b1;
                use_rb_o = 1'b1;
                writes_o = 1'b1;
                dst_o    = rc_s;
            end
            OP_ADDI, OP_LD: begin
                use_ra_o = 1'b1;
                writes_o = 1'b1;
                dst_o    = rb_o;
            end
            OP_ST, OP_BEQ: begin
                use_ra_o = 1'b1;
                use_rb_o = 1'b1;
            end
            OP_JMP: begin
                use_ra_o = 1'b1;
            end
            default: begin
                use_ra_o = 1'b0;
                use_rb_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_reg.sv
// ---------------------------------------------------------------------------
// id_reg
// ID-stage pipeline register. Decodes the IF slot, reads the register file,
// forwards ALU results from EX, detects load-use hazards, resolves branches
// and registers the decoded instruction into EX.
//   clk, reset          : clock, synchronous active-high reset
//   IFPC/IFInsn/IFEn    : IF slot (PC already +1), instruction, valid
//   Stall/Flush         : downstream hold / kill of the ID register
//   RaAddr/RbAddr       : combinational register-file read indices
//   RaData/RbData       : register-file read data
//   ExDstAddr/ExDstEn/ExIsLoad/ExFwdData : EX-stage forwarding/hazard info
//   LdStall             : combinational load-use stall towards IF
//   BrTaken/BrAddr      : combinational redirect towards IF
//   IDPC..IDEn          : registered decoded instruction for EX
// ---------------------------------------------------------------------------
module id_reg
    import id_reg_pkg::*;
#(
    parameter int WORD_ADDR_W = 30,
    parameter int WORD_DATA_W = 32,
    parameter int REG_ADDR_W  = CPU_REG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_ADDR_W-1:0] IFPC,
    input  logic [WORD_DATA_W-1:0] IFInsn,
    input  logic                   IFEn,
    input  logic                   Stall,
    input  logic                   Flush,
    output logic [REG_ADDR_W-1:0]  RaAddr,
    output logic [REG_ADDR_W-1:0]  RbAddr,
    input  logic [WORD_DATA_W-1:0] RaData,
    input  logic [WORD_DATA_W-1:0] RbData,
    input  logic [REG_ADDR_W-1:0]  ExDstAddr,
    input  logic                   ExDstEn,
    input  logic                   ExIsLoad,
    input  logic [WORD_DATA_W-1:0] ExFwdData,
    output logic                   LdStall,
    output logic                   BrTaken,
    output logic [WORD_ADDR_W-1:0] BrAddr,
    output logic [WORD_ADDR_W-1:0] IDPC,
    output logic [5:0]             IDOp,
    output logic [REG_ADDR_W-1:0]  IDDst,
    output logic                   IDDstEn,
    output logic [WORD_DATA_W-1:0] IDOpA,
    output logic [WORD_DATA_W-1:0] IDOpB,
    output logic [WORD_DATA_W-1:0] IDImm,
    output logic                   IDEn
);

    opcode_e                op_s;
    logic [REG_ADDR_W-1:0]  ra_s;
    logic [REG_ADDR_W-1:0]  rb_s;
    logic [REG_ADDR_W-1:0]  dst_s;
    logic                   use_ra_s;
    logic                   use_rb_s;
    logic                   writes_s;
    logic [WORD_DATA_W-1:0] imm_s;
    logic [WORD_DATA_W-1:0] opa_s;
    logic [WORD_DATA_W-1:0] opb_s;
    logic                   ld_stall_s;
    logic                   br_cond_s;
    logic                   br_taken_s;
    logic [WORD_ADDR_W-1:0] br_addr_s;

    logic [WORD_ADDR_W-1:0] pc_q,     pc_d;
    logic [5:0]             op_q,     op_d;
    logic [REG_ADDR_W-1:0]  dst_q,    dst_d;
    logic                   dst_en_q, dst_en_d;
    logic [WORD_DATA_W-1:0] opa_q,    opa_d;
    logic [WORD_DATA_W-1:0] opb_q,    opb_d;
    logic [WORD_DATA_W-1:0] imm_q,    imm_d;
    logic                   en_q,     en_d;

    id_decoder #(
        .WORD_DATA_W (WORD_DATA_W)
    ) u_dec (
        .insn_i   (IFInsn),
        .op_o     (op_s),
        .ra_o     (ra_s),
        .rb_o     (rb_s),
        .dst_o    (dst_s),
        .use_ra_o (use_ra_s),
        .use_rb_o (use_rb_s),
        .writes_o (writes_s),
        .imm_o    (imm_s)
    );

    assign RaAddr = ra_s;
    assign RbAddr = rb_s;

    // Operand select: r0 is hard zero, otherwise a non-load EX result wins
    // over the register file
    always_comb begin
        opa_s = '0;
        opb_s = '0;
        if (ra_s == '0) begin
            opa_s = '0;
        end else if (ExDstEn && (ExDstAddr == ra_s) && !ExIsLoad) begin
            opa_s = ExFwdData;
        end else begin
            opa_s = RaData;
        end
        if (rb_s == '0) begin
            opb_s = '0;
        end else if (ExDstEn && (ExDstAddr == rb_s) && !ExIsLoad) begin
            opb_s = ExFwdData;
        end else begin
            opb_s = RbData;
        end
    end

    // Load-use hazard only against sources the opcode really reads
    assign ld_stall_s = IFEn && ExIsLoad && ExDstEn && (ExDstAddr != '0) &&
                        ((use_ra_s && (ExDstAddr == ra_s)) ||
                         (use_rb_s && (ExDstAddr == rb_s)));

    assign br_cond_s  = ((op_s == OP_BEQ) && (opa_s == opb_s)) || (op_s == OP_JMP);
    assign br_taken_s = IFEn && !ld_stall_s && !Stall && !Flush && br_cond_s;

    // Redirect target; PC-relative add wraps at the address width
    always_comb begin
        br_addr_s = '0;
        if (!br_taken_s) begin
            br_addr_s = '0;
        end else if (op_s == OP_JMP) begin
            br_addr_s = opa_s[WORD_ADDR_W-1:0];
        end else begin
            br_addr_s = IFPC + imm_s[WORD_ADDR_W-1:0];
        end
    end

    assign LdStall = ld_stall_s;
    assign BrTaken = br_taken_s;
    assign BrAddr  = br_addr_s;

    // ID register next state: Flush > Stall > bubble (hazard or empty slot) > capture
    always_comb begin
        pc_d     = pc_q;
        op_d     = op_q;
        dst_d    = dst_q;
        dst_en_d = dst_en_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        imm_d    = imm_q;
        en_d     = en_q;
        if (Flush || (!Stall && (ld_stall_s || !IFEn))) begin
            pc_d     = '0;
            op_d     = RST_OP;
            dst_d    = '0;
            dst_en_d = RST_DST_EN;
            opa_d    = '0;
            opb_d    = '0;
            imm_d    = '0;
            en_d     = RST_EN;
        end else if (Stall) begin
            en_d     = en_q;
        end else begin
            pc_d     = IFPC;
            op_d     = op_s;
            dst_d    = dst_s;
            dst_en_d = writes_s && (dst_s != '0);
            opa_d    = opa_s;
            opb_d    = opb_s;
            imm_d    = imm_s;
            en_d     = 1'b1;
        end
    end

    // ID pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            op_q     <= RST_OP;
            dst_q    <= '0;
            dst_en_q <= RST_DST_EN;
            opa_q    <= '0;
            opb_q    <= '0;
            imm_q    <= '0;
            en_q     <= RST_EN;
        end else begin
            pc_q     <= pc_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            dst_en_q <= dst_en_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            imm_q    <= imm_d;
            en_q     <= en_d;
        end
    end

    assign IDPC    = pc_q;
    assign IDOp    = op_q;
    assign IDDst   = dst_q;
    assign IDDstEn = dst_en_q;
    assign IDOpA   = opa_q;
    assign IDOpB   = opb_q;
    assign IDImm   = imm_q;
    assign IDEn    = en_q;

endmodule
